uart_rx_mv: RTL and testbench

UART_RX_MV -- requirements
Module: uart_rx_mv

---
 rtl/uart_rx_mv.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_mv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mv.sv
// rtl/uart_rx_mv.sv - oversampling UART receiver with 7-sample majority vote
//
// Purpose: receives asynchronous serial frames (start, DATA_BITS data LSB-first,
// optional parity, one stop bit). Each bit is oversampled OVS times; its value is
// the majority of the 7 samples around mid-bit.
//
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit after the data
// bits, checked even or odd according to PARITY_ODD). Default build has no parity.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset_n     in   asynchronous active-low reset
//   Baud_set    in   [2:0] baud select, 0=9600 1=19200 2=38400 3=57600 4=115200, else 9600
//   usart_rx    in   asynchronous serial line, idle high
//   Data        out  [DATA_BITS-1:0] last good received word
//   Rx_Done     out  one-cycle pulse when Data has been updated
//   Frame_err   out  one-cycle pulse when the stop bit votes 0
//   Parity_err  out  one-cycle pulse on parity mismatch (constant 0 without parity)

module uart_rx_mv #(
  parameter int CLK_FREQ   = 50000000,
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [2:0]           Baud_set,
  input  logic                 usart_rx,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Rx_Done,
  output logic                 Frame_err,
  output logic                 Parity_err
);

  // Elaboration-time guard on the legal parameter space.
  if (DATA_BITS < 5 || DATA_BITS > 9 || OVS < 8 || OVS > 32 || (OVS % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_mv: illegal parameter value");
  end

  localparam int TC_9600 = CLK_FREQ / (9600 * OVS) - 1;
  // The 9600 count is the largest, so it sizes the divider.
  localparam int DIV_W   = (TC_9600 < 2) ? 1 : $clog2(TC_9600 + 1);
  localparam int TICK_W  = $clog2(OVS);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] TC_9600_T   = DIV_W'(TC_9600);
  localparam logic [DIV_W-1:0] TC_19200_T  = DIV_W'(CLK_FREQ / (19200 * OVS) - 1);
  localparam logic [DIV_W-1:0] TC_38400_T  = DIV_W'(CLK_FREQ / (38400 * OVS) - 1);
  localparam logic [DIV_W-1:0] TC_57600_T  = DIV_W'(CLK_FREQ / (57600 * OVS) - 1);
  localparam logic [DIV_W-1:0] TC_115200_T = DIV_W'(CLK_FREQ / (115200 * OVS) - 1);

  localparam logic [TICK_W-1:0] SMP_LO   = TICK_W'(OVS / 2 - 3);
  localparam logic [TICK_W-1:0] SMP_HI   = TICK_W'(OVS / 2 + 3);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [1:0]           sync_ff;
  logic [1:0]           sync_vld;
  logic                 rx_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     tc_q;
  logic [DIV_W-1:0]     baud_tc;
  logic [TICK_W-1:0]    tick_cnt;
  logic [2:0]           ones_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 start_bad;

  logic       rx_s;
  logic       fall;
  logic       tick;
  logic       in_win;
  logic       last_smp;
  logic       bit_end;
  logic [2:0] ones_next;
  logic       vote;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = (^shreg) ^ par_bit ^ ODD;
`else
  assign Parity_err = 1'b0;
`endif

  always_comb begin
    case (Baud_set)
      3'd1:    baud_tc = TC_19200_T;
      3'd2:    baud_tc = TC_38400_T;
      3'd3:    baud_tc = TC_57600_T;
      3'd4:    baud_tc = TC_115200_T;
      default: baud_tc = TC_9600_T;
    endcase
  end

  // sync_vld tracks when the synchroniser holds real line data rather than its
  // reset value; rx_prev only follows valid data so that a line held low through
  // reset release cannot look like a fresh start edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_ff  <= 2'b11;
      sync_vld <= 2'b00;
      rx_prev  <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[0], usart_rx};
      sync_vld <= {sync_vld[0], 1'b1};
      rx_prev  <= sync_vld[1] ? sync_ff[1] : 1'b0;
    end
  end

  assign rx_s      = sync_ff[1];
  assign fall      = sync_vld[1] & rx_prev & ~rx_s;
  assign tick      = (div_cnt == tc_q);
  assign in_win    = (tick_cnt >= SMP_LO) && (tick_cnt <= SMP_HI);
  assign last_smp  = (tick_cnt == SMP_HI);
  assign bit_end   = (tick_cnt == TICK_MAX);
  assign ones_next = ones_cnt + {2'b00, rx_s};
  // On the last sample tick, ones_next already includes that sample.
  assign vote      = (ones_next >= 3'd4);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tc_q      <= '0;
      tick_cnt  <= '0;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      start_bad <= 1'b0;
      Data      <= '0;
      Rx_Done   <= 1'b0;
      Frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      Parity_err <= 1'b0;
`endif
    end else begin
      Rx_Done   <= 1'b0;
      Frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_err <= 1'b0;
`endif
      if (state == IDLE) begin
        if (fall) begin
          state    <= START;
          div_cnt  <= '0;
          tick_cnt <= '0;
          ones_cnt <= '0;
          bit_cnt  <= '0;
          tc_q     <= baud_tc;
        end
      end else if (!tick) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt  <= '0;
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
        if (in_win) ones_cnt <= last_smp ? 3'd0 : ones_next;

        if (last_smp) begin
          case (state)
            START:  start_bad <= vote;
            DATA:   shreg     <= {vote, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            PARITY: par_bit   <= vote;
`endif
            STOP: begin
              // Finish mid stop-bit so a following start edge is not missed.
              state     <= IDLE;
              Frame_err <= ~vote;
`ifdef UART_RX_PARITY_EN
              Parity_err <= par_bad;
              if (vote && !par_bad) begin
`else
              if (vote) begin
`endif
                Data    <= shreg;
                Rx_Done <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        if (bit_end) begin
          case (state)
            START: state <= start_bad ? IDLE : DATA;
            DATA: begin
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: state <= STOP;
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mv.sv
// tb/tb_uart_rx_mv.sv - directed self-checking bench for uart_rx_mv

module tb_uart_rx_mv;

  logic       Clk;
  logic       Reset_n;
  logic [2:0] Baud_set;
  logic       usart_rx;
  logic [7:0] Data;
  logic       Rx_Done;
  logic       Frame_err;
  logic       Parity_err;

  uart_rx_mv dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Baud_set  (Baud_set),
    .usart_rx  (usart_rx),
    .Data      (Data),
    .Rx_Done   (Rx_Done),
    .Frame_err (Frame_err),
    .Parity_err(Parity_err)
  );

  // 50 MHz: 115200 baud -> 27 clocks/tick, 432 clocks/bit; 9600 -> 325, 5200.
  localparam int BCLK_FAST = 432;
  localparam int BCLK_SLOW = 5200;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
  logic par_flip = 1'b0;
`else
  localparam int STOP_IDX = 9;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_ferr   = 0;
  int n_perr   = 0;
  int t_done   = 0;
  int t_ferr   = 0;
  int t_perr   = 0;
  int t_start  = 0;
  int rst_bit  = -1;
  int chg_bit  = -1;
  logic [2:0] chg_val = 3'd4;
  int inj_off  = 0;
  int inj_len [0:11];
  int d0, f0, p0;

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Count high cycles, so a stretched pulse shows up as a count above one.
  always @(negedge Clk) begin
    if (Rx_Done)    begin n_done++; t_done = cyc; end
    if (Frame_err)  begin n_ferr++; t_ferr = cyc; end
    if (Parity_err) begin n_perr++; t_perr = cyc; end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int bclk, input int b);
    if (b == chg_bit) Baud_set = chg_val;
    if (b == rst_bit) begin
      usart_rx = v;
      repeat (bclk / 2) @(negedge Clk);
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      check_eq("rst_mid_data", Data, 32'h0);
      check_eq("rst_mid_done", Rx_Done, 32'h0);
      check_eq("rst_mid_ferr", Frame_err, 32'h0);
      check_eq("rst_mid_perr", Parity_err, 32'h0);
      Reset_n = 1'b1;
      repeat (bclk - bclk / 2 - 3) @(negedge Clk);
    end else if (inj_len[b] > 0) begin
      usart_rx = v;
      repeat (inj_off) @(negedge Clk);
      usart_rx = ~v;
      repeat (inj_len[b]) @(negedge Clk);
      usart_rx = v;
      repeat (bclk - inj_off - inj_len[b]) @(negedge Clk);
    end else begin
      usart_rx = v;
      repeat (bclk) @(negedge Clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop_v);
    logic fb [0:11];
    int   nb;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i + 1] = d[i];
    nb = 9;
`ifdef UART_RX_PARITY_EN
    fb[nb] = (^d) ^ par_flip;
    nb++;
`endif
    fb[nb] = stop_v;
    nb++;
    t_start = cyc;
    for (int b = 0; b < nb; b++) drive_bit(fb[b], bclk, b);
    usart_rx = 1'b1;
    repeat (40) @(negedge Clk);
    for (int b = 0; b < 12; b++) inj_len[b] = 0;
    rst_bit = -1;
    chg_bit = -1;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
  endtask

  task automatic snap;
    d0 = n_done;
    f0 = n_ferr;
    p0 = n_perr;
  endtask

  initial begin
    for (int b = 0; b < 12; b++) inj_len[b] = 0;
    Reset_n  = 1'b0;
    Baud_set = 3'd4;
    usart_rx = 1'b1;
    repeat (5) @(negedge Clk);
    check_eq("reset_data", Data, 32'h0);
    check_eq("reset_done", Rx_Done, 32'h0);
    check_eq("reset_ferr", Frame_err, 32'h0);
    check_eq("reset_perr", Parity_err, 32'h0);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);

    // 0xA5 at 115200; completion lands in the second half of the stop bit.
    snap();
    send_frame(8'hA5, BCLK_FAST, 1'b1);
    check_eq("a5_data", Data, 32'hA5);
    check_eq("a5_done", n_done - d0, 32'd1);
    check_eq("a5_ferr", n_ferr - f0, 32'd0);
    check_eq("a5_mid_stop",
             (t_done > t_start + STOP_IDX * BCLK_FAST + BCLK_FAST / 2) &&
             (t_done < t_start + (STOP_IDX + 1) * BCLK_FAST), 32'd1);

    // 0x3C at 9600 with inverted pulses: 2 ticks in data bit 3, 3 ticks in data
    // bit 6 (4 of 7 samples still correct). Baud_set changes mid-frame.
    snap();
    Baud_set = 3'd0;
    chg_bit  = 2;
    chg_val  = 3'd4;
    inj_off  = 2050;
    inj_len[4] = 650;
    inj_len[7] = 975;
    send_frame(8'h3C, BCLK_SLOW, 1'b1);
    check_eq("3c_data", Data, 32'h3C);
    check_eq("3c_done", n_done - d0, 32'd1);
    check_eq("3c_ferr", n_ferr - f0, 32'd0);

    // 3-tick low glitch on idle line is a false start.
    snap();
    usart_rx = 1'b0;
    repeat (81) @(negedge Clk);
    usart_rx = 1'b1;
    repeat (500) @(negedge Clk);
    check_eq("glitch_done", n_done - d0, 32'd0);
    check_eq("glitch_ferr", n_ferr - f0, 32'd0);
    check_eq("glitch_perr", n_perr - p0, 32'd0);
    send_frame(8'h5A, BCLK_FAST, 1'b1);
    check_eq("5a_data", Data, 32'h5A);
    check_eq("5a_done", n_done - d0, 32'd1);

    // 0x81 with stop bit low.
    snap();
    send_frame(8'h81, BCLK_FAST, 1'b0);
    check_eq("81_ferr", n_ferr - f0, 32'd1);
    check_eq("81_done", n_done - d0, 32'd0);
    check_eq("81_data_kept", Data, 32'h5A);

    // Reset in the middle of data bit 4 of 0x0F; line stays low after release.
    snap();
    rst_bit = 5;
    send_frame(8'h0F, BCLK_FAST, 1'b1);
    check_eq("rst_no_done", n_done - d0, 32'd0);
    check_eq("rst_no_ferr", n_ferr - f0, 32'd0);
    check_eq("rst_data_zero", Data, 32'h0);
    send_frame(8'h42, BCLK_FAST, 1'b1);
    check_eq("42_data", Data, 32'h42);
    check_eq("42_done", n_done - d0, 32'd1);

`ifdef UART_RX_PARITY_EN
    snap();
    par_flip = 1'b1;
    send_frame(8'h01, BCLK_FAST, 1'b1);
    check_eq("par_bad_perr", n_perr - p0, 32'd1);
    check_eq("par_bad_done", n_done - d0, 32'd0);
    check_eq("par_bad_data", Data, 32'h42);
    snap();
    send_frame(8'h01, BCLK_FAST, 1'b1);
    check_eq("par_ok_data", Data, 32'h01);
    check_eq("par_ok_done", n_done - d0, 32'd1);
    check_eq("par_ok_perr", n_perr - p0, 32'd0);
    snap();
    par_flip = 1'b1;
    send_frame(8'h01, BCLK_FAST, 1'b0);
    check_eq("both_perr", n_perr - p0, 32'd1);
    check_eq("both_ferr", n_ferr - f0, 32'd1);
    check_eq("both_same_cycle", t_perr == t_ferr, 32'd1);
    check_eq("both_done", n_done - d0, 32'd0);
`else
    check_eq("perr_never", n_perr, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
